// File: rtl/ram_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_rd_arbiter_if
//
// Bundles the two requester channels and the memory read port of the
// 256x16 read arbiter.
//
// Signals
//   req0_addr/req1_addr    [7:0]  requester read address
//   req0_valid/req1_valid         requester request valid
//   req0_ready/req1_ready         request accepted this cycle (combinational)
//   rsp0_data/rsp1_data    [15:0] returned read data
//   rsp0_valid/rsp1_valid         single-cycle data pulse, no back-pressure
//   ram_rd_addr            [7:0]  memory read address
//   ram_rd_read                   memory read strobe
//   ram_rd_data            [15:0] memory read data
//   ram_rd_valid                  memory read data valid
//
// Modports
//   slave  : the arbiter's view (serves requesters, drives the memory port)
//   master : the environment's view (requesters plus the memory block)
// ---------------------------------------------------------------------------
interface ram_rd_arbiter_if;
  logic [7:0]  req0_addr;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] rsp0_data;
  logic        rsp0_valid;

  logic [7:0]  req1_addr;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] rsp1_data;
  logic        rsp1_valid;

  logic [7:0]  ram_rd_addr;
  logic        ram_rd_read;
  logic [15:0] ram_rd_data;
  logic        ram_rd_valid;

  modport slave (
    input  req0_addr, req0_valid,
    output req0_ready, rsp0_data, rsp0_valid,
    input  req1_addr, req1_valid,
    output req1_ready, rsp1_data, rsp1_valid,
    output ram_rd_addr, ram_rd_read,
    input  ram_rd_data, ram_rd_valid
  );

  modport master (
    output req0_addr, req0_valid,
    input  req0_ready, rsp0_data, rsp0_valid,
    output req1_addr, req1_valid,
    input  req1_ready, rsp1_data, rsp1_valid,
    input  ram_rd_addr, ram_rd_read,
    output ram_rd_data, ram_rd_valid
  );
endinterface

// File: rtl/ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rd_arbiter
//
// Two-port read arbiter and sequencer for the 256x16 fixed-latency memory.
// Accepts reads from two requesters, issues at most one memory read per
// clock, tracks each in-flight read by requester ID in a tag pipeline that
// lines up with the memory's return, routes returned words to the issuing
// requester and bounds outstanding reads per requester with credit counters.
//
// Parameters
//   RD_LATENCY      memory latency, edge sampling ram_rd_read to edge
//                   driving ram_rd_valid (1..16)
//   MAX_OUTSTANDING in-flight reads allowed per requester (1..15)
//
// Ports
//   clk     in   rising-edge clock
//   areset  in   asynchronous active-high reset
//   bus     slave modport of ram_rd_arbiter_if (requesters + memory port)
//   o_err   out  sticky: memory return did not match the tag pipeline
//
// Build option
//   RAM_RD_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie;
//                             otherwise ties are resolved round-robin.
//
// Accept-to-response latency is RD_LATENCY+2 clocks.
// ---------------------------------------------------------------------------
module ram_rd_arbiter #(
  parameter int RD_LATENCY      = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            areset,
  ram_rd_arbiter_if.slave bus,
  output logic            o_err
);

  // Index of the tag stage that lines up with ram_rd_valid.
  localparam int         TAIL       = RD_LATENCY;
  localparam logic [3:0] CNT_MAX    = 4'(MAX_OUTSTANDING);
  // Mismatch detection is blanked for this many clocks after reset so that
  // returns of reads issued before reset are silently dropped.
  localparam logic [4:0] GUARD_INIT = 5'(RD_LATENCY + 1);

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Credit counter update: +1 on accept, -1 on response, hold when both.
  function automatic logic [3:0] f_credit_next(
    input logic [3:0] cnt,
    input logic       inc,
    input logic       dec
  );
    logic [3:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = cnt + 4'd1;
      2'b01:   nxt = cnt - 4'd1;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0]        r_cnt0;
  logic [3:0]        r_cnt1;
  logic [7:0]        r_rd_addr;
  logic              r_rd_read;
  logic              r_issue_id;
  logic [TAIL:0]     r_tag_vld;
  logic [TAIL:0]     r_tag_id;
  logic [15:0]       r_rsp0_data;
  logic              r_rsp0_valid;
  logic [15:0]       r_rsp1_data;
  logic              r_rsp1_valid;
  logic              r_err;
  logic [4:0]        r_guard;
`ifndef RAM_RD_ARB_FIXED_PRIO_EN
  logic              r_last_grant;
`endif

  logic              w_elig0;
  logic              w_elig1;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_tail_vld;
  logic              w_tail_id;
  logic              w_ret;
  logic              w_mismatch;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign w_elig0 = bus.req0_valid && (r_cnt0 < CNT_MAX);
  assign w_elig1 = bus.req1_valid && (r_cnt1 < CNT_MAX);

  // Grant selection: a lone eligible requester wins; ties go by priority mode.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case ({w_elig1, w_elig0})
      2'b01: begin
        w_grant0 = 1'b1;
        w_grant1 = 1'b0;
      end
      2'b10: begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b1;
      end
      2'b11: begin
`ifdef RAM_RD_ARB_FIXED_PRIO_EN
        w_grant0 = 1'b1;
        w_grant1 = 1'b0;
`else
        // last_grant=1 means requester 1 went last, so requester 0 wins.
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
`endif
      end
      default: begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
      end
    endcase
  end

  assign w_acc0 = bus.req0_valid & w_grant0;
  assign w_acc1 = bus.req1_valid & w_grant1;

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

`ifndef RAM_RD_ARB_FIXED_PRIO_EN
  // Round-robin history: remembers which requester was accepted last.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_last_grant <= 1'b1;
    end else if (w_acc0) begin
      r_last_grant <= 1'b0;
    end else if (w_acc1) begin
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Memory read issue
  // -------------------------------------------------------------------------
  // Registered read strobe/address; the address holds when nothing is issued.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rd_read  <= 1'b0;
      r_rd_addr  <= 8'h00;
      r_issue_id <= 1'b0;
    end else begin
      r_rd_read  <= w_acc0 | w_acc1;
      r_issue_id <= w_acc1;
      if (w_acc0) begin
        r_rd_addr <= bus.req0_addr;
      end else if (w_acc1) begin
        r_rd_addr <= bus.req1_addr;
      end else begin
        r_rd_addr <= r_rd_addr;
      end
    end
  end

  assign bus.ram_rd_read = r_rd_read;
  assign bus.ram_rd_addr = r_rd_addr;

  // -------------------------------------------------------------------------
  // Tag pipeline
  // -------------------------------------------------------------------------
  // The issue register acts as the head; RD_LATENCY+1 further stages make the
  // tail coincide with ram_rd_valid for the read it describes.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[TAIL-1:0], r_rd_read};
      r_tag_id  <= {r_tag_id[TAIL-1:0], r_issue_id};
    end
  end

  assign w_tail_vld = r_tag_vld[TAIL];
  assign w_tail_id  = r_tag_id[TAIL];
  assign w_ret      = w_tail_vld & bus.ram_rd_valid;
  assign w_mismatch = (w_tail_vld != bus.ram_rd_valid) && (r_guard == 5'd0);

  // -------------------------------------------------------------------------
  // Response routing
  // -------------------------------------------------------------------------
  // A matched return pulses the tail ID's valid; the other channel's data holds.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= 16'h0000;
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= 16'h0000;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (w_ret && !w_tail_id) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_data  <= bus.ram_rd_data;
      end else if (w_ret && w_tail_id) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= bus.ram_rd_data;
      end else begin
        r_rsp0_data  <= r_rsp0_data;
        r_rsp1_data  <= r_rsp1_data;
      end
    end
  end

  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp0_data  = r_rsp0_data;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp1_data  = r_rsp1_data;

  // -------------------------------------------------------------------------
  // Credits
  // -------------------------------------------------------------------------
  // Outstanding-read counters; the credit is returned in the response cycle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt0 <= 4'd0;
      r_cnt1 <= 4'd0;
    end else begin
      r_cnt0 <= f_credit_next(r_cnt0, w_acc0, r_rsp0_valid);
      r_cnt1 <= f_credit_next(r_cnt1, w_acc1, r_rsp1_valid);
    end
  end

  // -------------------------------------------------------------------------
  // Error detection
  // -------------------------------------------------------------------------
  // Post-reset blanking counter, counts down to zero once.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_guard <= GUARD_INIT;
    end else if (r_guard != 5'd0) begin
      r_guard <= r_guard - 5'd1;
    end else begin
      r_guard <= r_guard;
    end
  end

  // Sticky mismatch flag: data without a tag, or a tag without data.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_err <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
module tb_ram_rd_arbiter;
  localparam int RD_LAT  = 6;
  localparam int MAX_OUT = 4;

  logic clk    = 1'b0;
  logic areset = 1'b1;
  logic err;

  ram_rd_arbiter_if bus ();

  ram_rd_arbiter #(.RD_LATENCY(RD_LAT), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory block model: samples ram_rd_read, returns RD_LAT edges later.
  logic [15:0] mem [0:255];
  logic        m_vld [0:RD_LAT] = '{default: 1'b0};
  logic [15:0] m_dat [0:RD_LAT] = '{default: 16'h0000};
  logic        inj_vld  = 1'b0;
  logic        mem_drop = 1'b0;

  always @(posedge clk) begin
    m_vld[0] <= bus.ram_rd_read & ~mem_drop;
    m_dat[0] <= mem[bus.ram_rd_addr];
    for (int k = 1; k <= RD_LAT; k++) begin
      m_vld[k] <= m_vld[k-1];
      m_dat[k] <= m_dat[k-1];
    end
  end

  assign bus.ram_rd_valid = m_vld[RD_LAT] | inj_vld;
  assign bus.ram_rd_data  = m_dat[RD_LAT];

  // Reference model: outstanding counts, tie history and a queue of expected
  // responses stamped with the edge on which they become visible.
  typedef struct packed {
    int         due;
    logic       id;
    logic [7:0] addr;
  } exp_t;

  exp_t        q[$];
  int          m_cyc = 0;
  int          m_cnt [2] = '{0, 0};
  logic        m_last = 1'b1;
  logic        m_rsp_vld [2] = '{1'b0, 1'b0};
  logic [15:0] m_rsp_data [2] = '{16'h0000, 16'h0000};

  function automatic logic model_ready(input int who);
    logic e0, e1;
    e0 = bus.req0_valid && (m_cnt[0] < MAX_OUT);
    e1 = bus.req1_valid && (m_cnt[1] < MAX_OUT);
    if (e0 && e1) begin
`ifdef RAM_RD_ARB_FIXED_PRIO_EN
      return (who == 0);
`else
      return (who == 0) ? m_last : ~m_last;
`endif
    end
    return (who == 0) ? e0 : e1;
  endfunction

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      q.delete();
      m_cnt[0]      <= 0;
      m_cnt[1]      <= 0;
      m_last        <= 1'b1;
      m_rsp_vld[0]  <= 1'b0;
      m_rsp_vld[1]  <= 1'b0;
      m_rsp_data[0] <= 16'h0000;
      m_rsp_data[1] <= 16'h0000;
    end else begin
      m_cyc <= m_cyc + 1;
      m_cnt[0] <= m_cnt[0] + (model_ready(0) ? 1 : 0) - (m_rsp_vld[0] ? 1 : 0);
      m_cnt[1] <= m_cnt[1] + (model_ready(1) ? 1 : 0) - (m_rsp_vld[1] ? 1 : 0);
      m_rsp_vld[0] <= 1'b0;
      m_rsp_vld[1] <= 1'b0;
      if (q.size() > 0 && q[0].due == m_cyc + 1) begin
        m_rsp_vld[q[0].id]  <= 1'b1;
        m_rsp_data[q[0].id] <= mem[q[0].addr];
        void'(q.pop_front());
      end
      if (model_ready(0)) begin
        q.push_back('{due: m_cyc + 1 + RD_LAT + 2, id: 1'b0, addr: bus.req0_addr});
        m_last <= 1'b0;
      end else if (model_ready(1)) begin
        q.push_back('{due: m_cyc + 1 + RD_LAT + 2, id: 1'b1, addr: bus.req1_addr});
        m_last <= 1'b1;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.ram_rd_read, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: rsp0v,rsp1v,read,err=%b required 0000",
               {bus.rsp0_valid, bus.rsp1_valid, bus.ram_rd_read, err});
    end
    n_tests++;
    if (bus.ram_rd_addr !== 8'h00 || bus.rsp0_data !== 16'h0000 || bus.rsp1_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h d0=%h d1=%h required zeros",
               bus.ram_rd_addr, bus.rsp0_data, bus.rsp1_data);
    end
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: %b required 00", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic test_tie();
    logic exp0;
    logic exp_id[$];
    logic got_id[$];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_addr = 8'h01;
      bus.req1_valid = 1'b1; bus.req1_addr = 8'h02;
      #1;
`ifdef RAM_RD_ARB_FIXED_PRIO_EN
      exp0 = (k < 4);
`else
      exp0 = (k % 2 == 0);
`endif
      exp_id.push_back(~exp0);
      n_tests++;
      if (bus.req0_ready !== exp0 || bus.req1_ready !== ~exp0) begin
        n_fail++;
        $display("FAIL tie_grant cycle %0d: ready0/1=%b%b required %b%b",
                 k, bus.req0_ready, bus.req1_ready, exp0, ~exp0);
      end
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      #1;
      if (bus.rsp0_valid === 1'b1) begin
        got_id.push_back(1'b0);
        n_tests++;
        if (bus.rsp0_data !== mem[8'h01]) begin
          n_fail++;
          $display("FAIL tie_data0: %h required %h", bus.rsp0_data, mem[8'h01]);
        end
      end
      if (bus.rsp1_valid === 1'b1) begin
        got_id.push_back(1'b1);
        n_tests++;
        if (bus.rsp1_data !== mem[8'h02]) begin
          n_fail++;
          $display("FAIL tie_data1: %h required %h", bus.rsp1_data, mem[8'h02]);
        end
      end
    end
    n_tests++;
    if (got_id.size() != 8) begin
      n_fail++;
      $display("FAIL tie_rsp_count: %0d required 8", got_id.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_id[i] !== exp_id[i]) begin
          n_fail++;
          $display("FAIL tie_order idx %0d: id %b required %b", i, got_id[i], exp_id[i]);
        end
      end
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 8'h12; bus.req1_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: %b required 1", bus.req0_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.ram_rd_read !== 1'b1 || bus.ram_rd_addr !== 8'h12) begin
      n_fail++;
      $display("FAIL single_issue: read=%b addr=%h required 1/12", bus.ram_rd_read, bus.ram_rd_addr);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.rsp0_valid !== (k == 8) || bus.rsp1_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL single_timing edge+%0d: rsp0v=%b rsp1v=%b err=%b required %b/0/0",
                 k, bus.rsp0_valid, bus.rsp1_valid, err, (k == 8));
      end
      if (k == 8) begin
        n_tests++;
        if (bus.rsp0_data !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL single_data: %h required beef", bus.rsp0_data);
        end
      end
    end
  endtask

  task automatic test_credit_stall();
    int acc_n = 0;
    int rsp_n = 0;
    int outst;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      bus.req0_valid = (c < 30);
      bus.req0_addr  = 8'($urandom_range(0, 255));
      bus.req1_valid = 1'b0;
      #1;
      outst = acc_n - rsp_n;
      n_tests++;
      if (bus.req0_ready !== model_ready(0)) begin
        n_fail++;
        $display("FAIL credit_ready cycle %0d: %b required %b", c, bus.req0_ready, model_ready(0));
      end
      if (c < 4 || c == 4) begin
        n_tests++;
        if (bus.req0_ready !== (c < 4)) begin
          n_fail++;
          $display("FAIL credit_burst cycle %0d: ready0=%b required %b", c, bus.req0_ready, (c < 4));
        end
      end
      n_tests++;
      if (outst > MAX_OUT || outst < 0 || (c >= 5 && c < 30 && outst < MAX_OUT - 1)) begin
        n_fail++;
        $display("FAIL credit_outstanding cycle %0d: %0d required within limits", c, outst);
      end
      n_tests++;
      if (bus.rsp0_valid !== m_rsp_vld[0] || (m_rsp_vld[0] && bus.rsp0_data !== m_rsp_data[0])) begin
        n_fail++;
        $display("FAIL credit_rsp cycle %0d: v=%b d=%h required v=%b d=%h",
                 c, bus.rsp0_valid, bus.rsp0_data, m_rsp_vld[0], m_rsp_data[0]);
      end
      if (bus.rsp0_valid === 1'b1) rsp_n++;
      if (bus.req0_ready === 1'b1 && bus.req0_valid) acc_n++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 312; c++) begin
      @(negedge clk);
      bus.req0_valid = (c < 300) && ($urandom_range(0, 99) < 60);
      bus.req1_valid = (c < 300) && ($urandom_range(0, 99) < 60);
      bus.req0_addr  = 8'($urandom_range(0, 255));
      bus.req1_addr  = 8'($urandom_range(0, 255));
      #1;
      n_tests++;
      if (bus.req0_ready !== model_ready(0) || bus.req1_ready !== model_ready(1)) begin
        n_fail++;
        $display("FAIL rand_ready cycle %0d: %b%b required %b%b", c,
                 bus.req0_ready, bus.req1_ready, model_ready(0), model_ready(1));
      end
      n_tests++;
      if (bus.rsp0_valid !== m_rsp_vld[0] || (m_rsp_vld[0] && bus.rsp0_data !== m_rsp_data[0])) begin
        n_fail++;
        $display("FAIL rand_rsp0 cycle %0d: v=%b d=%h required v=%b d=%h",
                 c, bus.rsp0_valid, bus.rsp0_data, m_rsp_vld[0], m_rsp_data[0]);
      end
      n_tests++;
      if (bus.rsp1_valid !== m_rsp_vld[1] || (m_rsp_vld[1] && bus.rsp1_data !== m_rsp_data[1])) begin
        n_fail++;
        $display("FAIL rand_rsp1 cycle %0d: v=%b d=%h required v=%b d=%h",
                 c, bus.rsp1_valid, bus.rsp1_data, m_rsp_vld[1], m_rsp_data[1]);
      end
      n_tests++;
      if (err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_err cycle %0d: %b required 0", c, err);
      end
    end
  endtask

  task automatic test_mismatch();
    @(negedge clk);
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_pre: err=%b required 0", err);
    end
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    #1;
    n_tests++;
    if (err !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_detect: err=%b rsp=%b%b required 1/00", err, bus.rsp0_valid, bus.rsp1_valid);
    end
    repeat (5) @(negedge clk);
    #1;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL mm_sticky: err=%b required 1", err);
    end
    @(negedge clk);
    areset = 1'b1;
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_clear: err=%b required 0", err);
    end
    @(negedge clk);
    areset = 1'b0;
    // Inside the post-reset blanking window: must not flag.
    @(negedge clk);
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_guard: err=%b required 0", err);
    end
    repeat (RD_LAT + 2) @(negedge clk);
    // A read whose data never comes back: no response, error raised.
    mem_drop = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h33;
    #1;
    n_tests++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mm_drop_ready: %b required 1", bus.req1_ready);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    mem_drop = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.rsp1_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mm_drop_rsp cycle %0d: rsp1v=%b required 0", c, bus.rsp1_valid);
      end
    end
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL mm_drop_err: err=%b required 1", err);
    end
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic test_reset_midflight();
    repeat (RD_LAT + 3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 8'h80 | 8'($urandom_range(0, 127));
      #1;
      n_tests++;
      if (bus.req0_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mf_issue %0d: ready0=%b required 1", k, bus.req0_ready);
      end
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    areset = 1'b1;
    #1;
    n_tests++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.ram_rd_read, err} !== 4'b0000 ||
        bus.ram_rd_addr !== 8'h00 || bus.rsp0_data !== 16'h0000 || bus.rsp1_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL mf_async_clear: flags=%b addr=%h d0=%h d1=%h required zeros",
               {bus.rsp0_valid, bus.rsp1_valid, bus.ram_rd_read, err},
               bus.ram_rd_addr, bus.rsp0_data, bus.rsp1_data);
    end
    @(negedge clk);
    areset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({bus.rsp0_valid, bus.rsp1_valid, err} !== 3'b000) begin
        n_fail++;
        $display("FAIL mf_stale cycle %0d: rsp0v,rsp1v,err=%b required 000",
                 c, {bus.rsp0_valid, bus.rsp1_valid, err});
      end
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL mf_tie: ready0/1=%b%b required 10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_addr = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_addr = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    mem[8'h12] = 16'hBEEF;
    test_reset();
    test_tie();
    test_single_read();
    test_credit_stall();
    test_random();
    test_mismatch();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
